usart_tx_feeder: RTL
====================

Name: usart_tx_feeder

Overview:
- Bus-master front end that sits directly upstream of a USARTn instance and drives its ram_Addr/ramwe/dbus_in write port.
- On command it runs the USART configuration sequence: UBRRnH, UBRRnL, UCSRnC, UCSRnB.
- It then drains an internal byte FIFO into UDRn, pacing each write on the USART's data-register-empty indication.
- This replaces hand-sequenced core writes for streaming transmit.

Parameters:
- UDRn_Address, 12'h0C6, UDRn data register address.
- UCSRnB_Address, 12'h0C1, UCSRnB address.
- UCSRnC_Address, 12'h0C2, UCSRnC address.
- UBRRnH_Address, 12'h0C5, UBRRnH address.
- UBRRnL_Address, 12'h0C4, UBRRnL address.
- FIFO_DEPTH_LOG2, 3, FIFO depth = 2**FIFO_DEPTH_LOG2 (default 8).
- UDRE_HOLDOFF, 2, idle cycles after each UDRn write before udre_i is sampled again (minimum 1).

Ports:
- cp2  in  1  system clock; all logic on rising edge.
- ireset  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse: flush FIFO, begin configuration sequence.
- cfg_ubrr  in  12  baud divisor; [11:8] go to UBRRnH low nibble (upper nibble written 0), [7:0] go to UBRRnL.
- cfg_ucsrc  in  8  value written to UCSRnC.
- cfg_ucsrb  in  8  value written to UCSRnB.
- cfg_done  out  1  high while in RUN or HOLD.
- push_valid  in  1  producer offers a byte.
- push_data  in  8  byte to transmit.
- push_ready  out  1  FIFO not full; a byte is accepted when push_valid && push_ready.
- fifo_level  out  FIFO_DEPTH_LOG2+1  current occupancy.
- udre_i  in  1  USART UDRE level (UdreIRQ line).
- bus_gnt  in  1  bus granted this cycle; write strobes are issued only when high.
- ram_Addr  out  12  bus address.
- ramwe  out  1  write strobe, exactly one cycle per write.
- dbus_out  out  8  write data to USART dbus_in.

Behaviour:
- Reset (ireset=1 at an edge): state=IDLE, FIFO empty, fifo_level=0, ramwe=0, ram_Addr=0, dbus_out=0, cfg_done=0, holdoff counter=0. A reset mid-sequence abandons it with no further writes.
- push_ready is combinational: !full. A push accepted in cycle N makes fifo_level increment after edge N.
- FSM states: IDLE, W_UBRRH, W_UBRRL, W_UCSRC, W_UCSRB, RUN, HOLD.
- IDLE: cfg_start goes to W_UBRRH. Pushes are accepted in IDLE (FIFO fills) but nothing is sent.
- Each W_* state drives its register address and data. ramwe=bus_gnt.
  - If bus_gnt=1, advance to the next state on the next edge.
  - If bus_gnt=0, remain in the state with ramwe=0.
  - Order is fixed: UBRRH -> UBRRL -> UCSRC -> UCSRB -> RUN.
- Config values are captured into registers on cfg_start. Later changes to the cfg_* inputs do not affect a sequence in progress.
- RUN: if FIFO non-empty && udre_i && bus_gnt, then:
  - ram_Addr=UDRn_Address, dbus_out=FIFO head, ramwe=1 for this cycle;
  - pop the FIFO, load holdoff=UDRE_HOLDOFF, go to HOLD.
  - Otherwise ramwe=0.
- HOLD: ramwe=0, decrement holdoff; return to RUN when the counter reaches 0. udre_i is ignored in HOLD, because the USART's UDRE deassertion lags the write.
- cfg_start in any non-IDLE state: flush FIFO, go to W_UBRRH. Any push in the same cycle is dropped.
- Pop only considers occupancy at the start of the cycle. A byte pushed into an empty FIFO can be written no earlier than the next cycle.
- Simultaneous push and pop when not full: both take effect and fifo_level is unchanged.
- Push when full: ignored (push_ready=0), even if a pop occurs in the same cycle.
- FIFO pointers wrap modulo depth. Full/empty are distinguished by fifo_level.
- When ramwe=0, ram_Addr and dbus_out hold their last values.
- ramre is never driven; this block does not read.

Test Plan:
1. Reset then cfg_start with cfg_ubrr=12'h081, cfg_ucsrc=8'hC6, cfg_ucsrb=8'h18, bus_gnt=1 -> four consecutive ramwe pulses: (0C5,00), (0C4,81), (0C2,C6), (0C1,18). cfg_done=1 on the following cycle.
2. bus_gnt low for 3 cycles during W_UBRRL -> no strobe during stall; write (0C4,81) occurs in the first granted cycle; sequence otherwise unchanged.
3. In RUN push 8'h75, 8'hAA with udre_i=1 -> (0C6,75) write; UDRE_HOLDOFF=2 idle cycles; (0C6,AA) write; fifo_level returns to 0.
4. udre_i=0, push 8 bytes -> push_ready drops after the 8th, fifo_level=8, a 9th push is ignored. Raise udre_i -> bytes emitted in push order, 3 cycles apart.
5. Assert ireset during W_UCSRC with 3 bytes queued -> next cycle ramwe=0, fifo_level=0, cfg_done=0, state IDLE, no UDRn write.
6. cfg_start in RUN with 4 bytes queued -> FIFO flushed, full config sequence re-runs, no UDRn write until cfg_done=1.

Source files
------------

// File: rtl/usart_tx_feeder_if.sv
// rtl/usart_tx_feeder_if.sv - push stream and USART write-port bundle for usart_tx_feeder
interface usart_tx_feeder_if #(
  parameter int FIFO_DEPTH_LOG2 = 3
);
  logic                     push_valid;
  logic [7:0]               push_data;
  logic                     push_ready;
  logic [FIFO_DEPTH_LOG2:0] fifo_level;
  logic                     udre_i;
  logic                     bus_gnt;
  logic [11:0]              ram_Addr;
  logic                     ramwe;
  logic [7:0]               dbus_out;

  modport master (
    input  push_valid, push_data, udre_i, bus_gnt,
    output push_ready, fifo_level, ram_Addr, ramwe, dbus_out
  );

  modport slave (
    output push_valid, push_data, udre_i, bus_gnt,
    input  push_ready, fifo_level, ram_Addr, ramwe, dbus_out
  );
endinterface

// File: rtl/usart_tx_feeder.sv
// rtl/usart_tx_feeder.sv - configures a USART then streams a byte FIFO into UDRn
module usart_tx_feeder #(
  parameter logic [11:0] UDRn_Address    = 12'h0C6,
  parameter logic [11:0] UCSRnB_Address  = 12'h0C1,
  parameter logic [11:0] UCSRnC_Address  = 12'h0C2,
  parameter logic [11:0] UBRRnH_Address  = 12'h0C5,
  parameter logic [11:0] UBRRnL_Address  = 12'h0C4,
  parameter int          FIFO_DEPTH_LOG2 = 3,
  parameter int          UDRE_HOLDOFF    = 2
) (
  input  logic                  cp2,
  input  logic                  ireset,
  input  logic                  cfg_start,
  input  logic [11:0]           cfg_ubrr,
  input  logic [7:0]            cfg_ucsrc,
  input  logic [7:0]            cfg_ucsrb,
  output logic                  cfg_done,
  usart_tx_feeder_if.master     bus
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_L = (FIFO_DEPTH_LOG2+1)'(DEPTH);
  localparam int HW = $clog2(UDRE_HOLDOFF + 1);

  typedef enum logic [2:0] {
    IDLE, W_UBRRH, W_UBRRL, W_UCSRC, W_UCSRB, RUN, HOLD
  } state_t;

  state_t state, next_state;

  logic [11:0]                ubrr_q;
  logic [7:0]                 ucsrc_q, ucsrb_q;
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [FIFO_DEPTH_LOG2:0]   level;
  logic [HW-1:0]              hold_cnt;
  logic [11:0]                addr_q, wr_addr;
  logic [7:0]                 data_q, wr_data;
  logic                       wr_en, pop, push, full, empty;

  assign full            = (level == DEPTH_L);
  assign empty           = (level == '0);
  assign push            = bus.push_valid && !full && !cfg_start;
  assign bus.push_ready  = !full;
  assign bus.fifo_level  = level;
  assign cfg_done        = (state == RUN) || (state == HOLD);

  // A strobe never escapes in a reset cycle, so a reset mid-sequence writes nothing more.
  assign bus.ramwe    = wr_en && !ireset;
  assign bus.ram_Addr = bus.ramwe ? wr_addr : addr_q;
  assign bus.dbus_out = bus.ramwe ? wr_data : data_q;

  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    wr_addr    = addr_q;
    wr_data    = data_q;
    pop        = 1'b0;
    if (cfg_start) begin
      next_state = W_UBRRH;
    end else begin
      case (state)
        IDLE: ;
        W_UBRRH: begin
          wr_addr = UBRRnH_Address;
          wr_data = {4'h0, ubrr_q[11:8]};
          wr_en   = bus.bus_gnt;
          if (bus.bus_gnt) next_state = W_UBRRL;
        end
        W_UBRRL: begin
          wr_addr = UBRRnL_Address;
          wr_data = ubrr_q[7:0];
          wr_en   = bus.bus_gnt;
          if (bus.bus_gnt) next_state = W_UCSRC;
        end
        W_UCSRC: begin
          wr_addr = UCSRnC_Address;
          wr_data = ucsrc_q;
          wr_en   = bus.bus_gnt;
          if (bus.bus_gnt) next_state = W_UCSRB;
        end
        W_UCSRB: begin
          wr_addr = UCSRnB_Address;
          wr_data = ucsrb_q;
          wr_en   = bus.bus_gnt;
          if (bus.bus_gnt) next_state = RUN;
        end
        RUN: begin
          if (!empty && bus.udre_i && bus.bus_gnt) begin
            wr_addr    = UDRn_Address;
            wr_data    = mem[rd_ptr];
            wr_en      = 1'b1;
            pop        = 1'b1;
            next_state = HOLD;
          end
        end
        HOLD: begin
          // UDRE lags our write, so it is not trusted until the holdoff expires.
          if (hold_cnt <= HW'(1)) next_state = RUN;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge cp2) begin
    if (ireset) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      hold_cnt <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      ubrr_q   <= '0;
      ucsrc_q  <= '0;
      ucsrb_q  <= '0;
    end else begin
      state <= next_state;
      if (cfg_start) begin
        ubrr_q  <= cfg_ubrr;
        ucsrc_q <= cfg_ucsrc;
        ucsrb_q <= cfg_ucsrb;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        level   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
      if (bus.ramwe) begin
        addr_q <= wr_addr;
        data_q <= wr_data;
      end
      if (pop)
        hold_cnt <= HW'(UDRE_HOLDOFF);
      else if (state == HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

  always_ff @(posedge cp2) begin
    if (!ireset && push) mem[wr_ptr] <= bus.push_data;
  end
endmodule
